fwd_hazard_ctrl: RTL

Parametrised forwarding and load-use hazard controller for the EX stage of the pipelined RV32I core. It keeps its own shadow of destination-register tags for DEPTH stages ahead of EX and selects, per EX source operand, the youngest in-flight producer. It raises a stall when a source depends on load data that cannot yet be forwarded, and counts stall cycles and stall episodes for performance analysis.

---
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_hazard_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the EX stage and the forwarding/hazard controller.
// Latency: wires only.
// Backpressure: none; stall is a combinational request back to the pipeline.
interface fwd_hazard_ctrl_if #(
  parameter int DEPTH   = 2,
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int CNT_W   = 16
);
  localparam int SW = $clog2(DEPTH + 1);

  logic                   advance;
  logic                   flush;
  logic                   ex_valid;
  logic [AW-1:0]          ex_rd;
  logic                   ex_we;
  logic                   ex_is_load;
  logic [NUM_SRC*AW-1:0]  ex_rs;
  logic [NUM_SRC-1:0]     ex_rs_used;
  logic                   mem_resp;
  logic [NUM_SRC*SW-1:0]  fwd_sel;
  logic                   stall;
  logic [CNT_W-1:0]       stall_cycles;
  logic [CNT_W-1:0]       stall_events;

  // Pipeline side: drives the EX instruction description, consumes select/stall.
  modport master (
    output advance, flush, ex_valid, ex_rd, ex_we, ex_is_load, ex_rs, ex_rs_used, mem_resp,
    input  fwd_sel, stall, stall_cycles, stall_events
  );

  // Controller side.
  modport slave (
    input  advance, flush, ex_valid, ex_rd, ex_we, ex_is_load, ex_rs, ex_rs_used, mem_resp,
    output fwd_sel, stall, stall_cycles, stall_events
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-source select and load-use stall for the EX stage, with stall perf counters.
// Latency: fwd_sel/stall are combinational (zero cycle); shadow and counters update on clk.
// Backpressure: raises stall while a source needs load data not yet forwardable; flush overrides.
module fwd_hazard_ctrl #(
  parameter int DEPTH          = 2,
  parameter int NUM_SRC        = 2,
  parameter int AW             = 5,
  parameter int LOAD_FWD_STAGE = 1,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_hazard_ctrl_if.slave    hz
);
  localparam int SW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          ld;
  } shadow_t;

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  shadow_t          shd_q [1:DEPTH];
  shadow_t          shd_d [1:DEPTH];
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [NUM_SRC-1:0] hazard;
  logic             stall_w;
  logic             evt_inc;

  // Per source: youngest matching in-flight producer wins; a load there may block.
  always_comb begin
    logic [AW-1:0] rs_j;
    logic          hit;
    hz.fwd_sel = '0;
    hazard     = '0;
    rs_j       = '0;
    hit        = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      rs_j = hz.ex_rs[j*AW +: AW];
      hit  = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!hit && hz.ex_rs_used[j] && (rs_j != '0) && shd_q[k].v && (shd_q[k].rd == rs_j)) begin
          hit = 1'b1;
          hz.fwd_sel[j*SW +: SW] = SW'(k);
          if (shd_q[k].ld && ((k < LOAD_FWD_STAGE) || ((k == LOAD_FWD_STAGE) && !hz.mem_resp)))
            hazard[j] = 1'b1;
        end
      end
    end
  end

  assign stall_w  = hz.ex_valid & ~hz.flush & (|hazard);
  assign hz.stall = stall_w;

  // Shadow shift: stalled or flushed EX enters as a bubble; older stages always move.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) shd_d[k] = shd_q[k];
    if (hz.advance) begin
      shd_d[1] = {hz.ex_valid & hz.ex_we & (hz.ex_rd != '0) & ~stall_w & ~hz.flush,
                  hz.ex_rd, hz.ex_is_load};
      for (int k = 2; k <= DEPTH; k++) shd_d[k] = shd_q[k-1];
    end
  end

  // RUN/STALL tracker; an episode is counted only on entry to STALL.
  always_comb begin
    state_d = state_q;
    evt_inc = 1'b0;
    case (state_q)
      ST_RUN:   if (stall_w) begin state_d = ST_STALL; evt_inc = 1'b1; end
      ST_STALL: if (!stall_w) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    cyc_d = cyc_q;
    evt_d = evt_q;
    if (stall_w && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
    if (evt_inc && (evt_q != '1)) evt_d = evt_q + 1'b1;
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) shd_q[k] <= '0;
      state_q <= ST_RUN;
      cyc_q   <= '0;
      evt_q   <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) shd_q[k] <= shd_d[k];
      state_q <= state_d;
      cyc_q   <= cyc_d;
      evt_q   <= evt_d;
    end
  end

  assign hz.stall_cycles = cyc_q;
  assign hz.stall_events = evt_q;
endmodule
